sevenseg_capture: RTL and testbench

- Receive side of the chronometer's seven-segment display interface: watches the multiplexed, active-low segment and anode lines and reconstructs the displayed digit codes.
- Used as an on-chip display monitor and as the checker in chronometer self-test.
- Filters transients between digit scans, decodes segment patterns back to 4-bit codes, flags illegal patterns and signals each complete display frame.

---
 rtl/sevenseg_pkg.sv | 31 +++
 rtl/sevenseg_pattern_decode.sv | 40 ++++
 rtl/sevenseg_capture.sv | 154 +++++++++++++++
 tb/tb_sevenseg_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants and types for the seven-segment capture block
// Segment patterns are active-high after inversion, bit0 = segment a.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    CAPTURED = 2'd2
  } state_e;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// rtl/sevenseg_pattern_decode.sv - combinational segment pattern to digit code decoder
// SEVENSEG_HEX_AF_EN adds the A..F letter patterns as legal codes.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    code  = CODE_ILLEGAL;
    legal = 1'b0;
    blank = 1'b0;
    case (pattern)
      SEG_0:     begin code = 4'h0; legal = 1'b1; end
      SEG_1:     begin code = 4'h1; legal = 1'b1; end
      SEG_2:     begin code = 4'h2; legal = 1'b1; end
      SEG_3:     begin code = 4'h3; legal = 1'b1; end
      SEG_4:     begin code = 4'h4; legal = 1'b1; end
      SEG_5:     begin code = 4'h5; legal = 1'b1; end
      SEG_6:     begin code = 4'h6; legal = 1'b1; end
      SEG_7:     begin code = 4'h7; legal = 1'b1; end
      SEG_8:     begin code = 4'h8; legal = 1'b1; end
      SEG_9:     begin code = 4'h9; legal = 1'b1; end
`ifdef SEVENSEG_HEX_AF_EN
      SEG_A:     begin code = 4'hA; legal = 1'b1; end
      SEG_B:     begin code = 4'hB; legal = 1'b1; end
      SEG_C:     begin code = 4'hC; legal = 1'b1; end
      SEG_D:     begin code = 4'hD; legal = 1'b1; end
      SEG_E:     begin code = 4'hE; legal = 1'b1; end
      SEG_F:     begin code = 4'hF; legal = 1'b1; end
`endif
      SEG_BLANK: begin code = 4'h0; blank = 1'b1; end
      default:   begin code = CODE_ILLEGAL; end
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - reconstructs digit codes from multiplexed active-low seven-segment lines
// Letter decoding is enabled by SEVENSEG_HEX_AF_EN (handled in sevenseg_pattern_decode).
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    decode_err
);

  localparam logic [7:0]            STABLE_MAX = STABLE_CYCLES[7:0];
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [6:0]              s_seg_q, s_seg_d, p_seg_q, p_seg_d;
  logic [NUM_DIGITS-1:0]   s_an_q, s_an_d, p_an_q, p_an_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_q, err_d;

  logic                    changed;
  logic [NUM_DIGITS-1:0]   an_act;
  logic                    one_hot;
  logic                    multi;
  logic                    capture;
  logic                    err_set;
  logic [NUM_DIGITS-1:0]   cap_bits;
  logic [3:0]              dec_code;
  logic                    dec_legal;
  logic                    dec_blank;

  sevenseg_pattern_decode u_decode (
    .pattern (~s_seg_q),
    .code    (dec_code),
    .legal   (dec_legal),
    .blank   (dec_blank)
  );

  always_comb begin
    s_seg_d = seg_n;
    s_an_d  = an_n;
    p_seg_d = s_seg_q;
    p_an_d  = s_an_q;

    changed = ({s_seg_q, s_an_q} != {p_seg_q, p_an_q});
    an_act  = ~s_an_q;
    multi   = ((an_act & (an_act - AN_ONE)) != '0);
    one_hot = (an_act != '0) && !multi;

    // The count reflects how long the registered pattern has been unchanged.
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q >= STABLE_MAX) begin
      cnt_d = STABLE_MAX;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) state_d = TRACK;
      end
      TRACK: begin
        if (!one_hot) begin
          state_d = IDLE;
        end else if (cnt_d == STABLE_MAX) begin
          capture = 1'b1;
          state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        if (changed) state_d = one_hot ? TRACK : IDLE;
      end
      default: state_d = IDLE;
    endcase

    digits_d = digits_q;
    valid_d  = valid_q;
    cap_bits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && !s_an_q[i]) begin
        digits_d[4*i +: 4] = dec_code;
        valid_d[i]         = dec_legal;
        cap_bits[i]        = 1'b1;
      end
    end

    // A capture landing on the frame_done edge seeds the next frame.
    if (&mask_q) begin
      frame_done_d = 1'b1;
      mask_d       = cap_bits;
    end else begin
      frame_done_d = 1'b0;
      mask_d       = mask_q | cap_bits;
    end

    err_set = ((state_q == IDLE) && multi) || (capture && !dec_legal && !dec_blank);
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s_seg_q      <= '1;
      s_an_q       <= '1;
      p_seg_q      <= '1;
      p_an_q       <= '1;
      cnt_q        <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_seg_q      <= s_seg_d;
      s_an_q       <= s_an_d;
      p_seg_q      <= p_seg_d;
      p_an_q       <= p_an_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign decode_err  = err_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - scoreboard bench for sevenseg_capture
// Expected output changes are queued with the cycle they must appear in.
module tb_sevenseg_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        decode_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          c;
    logic [15:0] d;
    logic [3:0]  v;
    logic        e;
    logic        f;
  } exp_t;

  exp_t exp_q[$];

  sevenseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .err_clr     (err_clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .decode_err  (decode_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push(input int c, input logic [15:0] d, input logic [3:0] v,
                      input logic e, input logic f);
    exp_t x;
    x.c = c; x.d = d; x.v = v; x.e = e; x.f = f;
    exp_q.push_back(x);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic drive_digit(input logic [3:0] an, input logic [6:0] pat,
                             input logic [15:0] d, input logic [3:0] v,
                             input logic e, input bit frame);
    int b;
    b     = cyc;
    an_n  = an;
    seg_n = ~pat;
    push(b + 5, d, v, e, 1'b0);
    if (frame) begin
      push(b + 6, d, v, e, 1'b1);
      push(b + 7, d, v, e, 1'b0);
    end
    hold(8);
  endtask

  // Monitor: every change of the observable outputs consumes one expectation.
  initial begin
    logic [21:0] prev_snap;
    logic [21:0] snap;
    exp_t        x;
    prev_snap = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        snap = {digits, digit_valid, decode_err, frame_done};
        if (snap !== prev_snap) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got digits=%h valid=%b err=%b fd=%b",
                     cyc, digits, digit_valid, decode_err, frame_done);
          end else begin
            x = exp_q.pop_front();
            if (x.c != cyc || digits !== x.d || digit_valid !== x.v ||
                decode_err !== x.e || frame_done !== x.f) begin
              errors++;
              $display("FAIL output_event got cyc=%0d digits=%h valid=%b err=%b fd=%b expected cyc=%0d digits=%h valid=%b err=%b fd=%b",
                       cyc, digits, digit_valid, decode_err, frame_done,
                       x.c, x.d, x.v, x.e, x.f);
            end
          end
          prev_snap = snap;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int b;
    reset   = 1'b1;
    seg_n   = 7'h7F;
    an_n    = 4'hF;
    err_clr = 1'b0;
    hold(3);
    check("reset_digits", int'(digits), 0);
    check("reset_valid", int'(digit_valid), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_decode_err", int'(decode_err), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    hold(2);

    drive_digit(4'b1110, 7'h5B, 16'h0002, 4'b0001, 1'b0, 1'b0);

    drive_digit(4'b1110, 7'h06, 16'h0001, 4'b0001, 1'b0, 1'b0);
    drive_digit(4'b1101, 7'h5B, 16'h0021, 4'b0011, 1'b0, 1'b0);
    drive_digit(4'b1011, 7'h4F, 16'h0321, 4'b0111, 1'b0, 1'b0);
    drive_digit(4'b0111, 7'h66, 16'h4321, 4'b1111, 1'b0, 1'b1);

    // Blank digit 1 first so its valid bit is 0 while the glitches run.
    drive_digit(4'b1101, 7'h00, 16'h4301, 4'b1101, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      seg_n = ~7'h06;
      hold(3);
      seg_n = ~7'h5B;
      hold(3);
    end
    drive_digit(4'b1101, 7'h67, 16'h4391, 4'b1111, 1'b0, 1'b0);

    b     = cyc;
    an_n  = 4'b1100;
    seg_n = ~7'h3F;
    push(b + 3, 16'h4391, 4'b1111, 1'b1, 1'b0);
    hold(5);
    err_clr = 1'b1;
    hold(2);
    err_clr = 1'b0;
    hold(3);
    an_n = 4'hF;
    hold(3);
    err_clr = 1'b1;
    push(b + 14, 16'h4391, 4'b1111, 1'b0, 1'b0);
    hold(1);
    err_clr = 1'b0;
    hold(2);

    b = cyc;
`ifdef SEVENSEG_HEX_AF_EN
    drive_digit(4'b1110, 7'h77, 16'h439A, 4'b1111, 1'b0, 1'b0);
`else
    drive_digit(4'b1110, 7'h77, 16'h439F, 4'b1110, 1'b1, 1'b0);
    push(b + 11, 16'h439F, 4'b1110, 1'b0, 1'b0);
`endif
    an_n = 4'hF;
    hold(2);
    err_clr = 1'b1;
    hold(1);
    err_clr = 1'b0;
    hold(2);

    b     = cyc;
    an_n  = 4'b1011;
    seg_n = ~7'h7F;
    hold(3);
    reset = 1'b1;
    push(b + 4, 16'h0000, 4'b0000, 1'b0, 1'b0);
    hold(1);
    reset = 1'b0;
    push(b + 9, 16'h0800, 4'b0100, 1'b0, 1'b0);
    hold(8);
    drive_digit(4'b0111, 7'h07, 16'h7800, 4'b1100, 1'b0, 1'b0);
    drive_digit(4'b1110, 7'h3F, 16'h7800, 4'b1101, 1'b0, 1'b0);
    drive_digit(4'b1101, 7'h6D, 16'h7850, 4'b1111, 1'b0, 1'b1);

    hold(10);
    check("pending_expectations", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
